// File: rtl/rot_pkg.sv
// Shared widths and the state encoding for the rotate operand sequencer.
package rot_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_B = 3'd1,
        GET_C = 3'd2,
        EXEC  = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/rot_operand_seq.sv
// Sequences operand B and a count word from a bus into an external rotate-left unit and holds the result.
// Define ROT_OPERAND_SEQ_ROR_EN to turn op_ror into a right rotate (count mapped to 32 - count).
module rot_operand_seq
    import rot_pkg::*;
#(
    parameter bit CLR_ON_ACCEPT = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              op_ror,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] rot_b,
    output logic [CNT_W-1:0]  rot_c,
    input  logic [DATA_W-1:0] rot_a,
    output logic [DATA_W-1:0] z_data,
    output logic              z_valid,
    input  logic              z_ready,
    output logic              busy
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] b_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              ror_reg;
    logic [DATA_W-1:0] z_reg;
    logic [CNT_W-1:0]  eff_cnt;
    logic              take_word;
    logic              accept;
    logic              latch_op;

    // The count is stored already mapped, so rot_c is a plain register output.
`ifdef ROT_OPERAND_SEQ_ROR_EN
    assign eff_cnt = ror_reg ? (CNT_W'(0) - in_data[CNT_W-1:0]) : in_data[CNT_W-1:0];
`else
    logic unused_ror;
    assign unused_ror = ror_reg;
    assign eff_cnt    = in_data[CNT_W-1:0];
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        z_valid    = 1'b0;
        busy       = 1'b1;
        take_word  = 1'b0;
        accept     = 1'b0;
        latch_op   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    latch_op   = 1'b1;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                in_ready  = 1'b1;
                take_word = in_valid;
                if (in_valid) begin
                    state_next = GET_C;
                end
            end
            GET_C: begin
                in_ready  = 1'b1;
                take_word = in_valid;
                if (in_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = HOLD;
            end
            HOLD: begin
                z_valid = 1'b1;
                accept  = z_ready;
                if (z_ready) begin
                    latch_op   = start;
                    state_next = start ? GET_B : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            b_reg   <= '0;
            cnt_reg <= '0;
            ror_reg <= 1'b0;
            z_reg   <= '0;
        end else begin
            if (latch_op) begin
                ror_reg <= op_ror;
            end
            if (take_word && state == GET_B) begin
                b_reg <= in_data;
            end
            if (take_word && state == GET_C) begin
                cnt_reg <= eff_cnt;
            end
            if (state == EXEC) begin
                z_reg <= rot_a;
            end else if (accept && CLR_ON_ACCEPT) begin
                z_reg <= '0;
            end
        end
    end

    assign rot_b  = b_reg;
    assign rot_c  = cnt_reg;
    assign z_data = z_reg;

endmodule

// File: tb/tb_rot_operand_seq.sv
// Directed bench for rot_operand_seq with a behavioural rotate-left unit wired as a sibling.
module tb_rot_operand_seq;

    logic        clk;
    logic        clr;
    logic        start;
    logic        op_ror;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rot_b;
    logic [4:0]  rot_c;
    logic [31:0] rot_a;
    logic [31:0] z_data;
    logic        z_valid;
    logic        z_ready;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    rot_operand_seq dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .op_ror   (op_ror),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rot_b    (rot_b),
        .rot_c    (rot_c),
        .rot_a    (rot_a),
        .z_data   (z_data),
        .z_valid  (z_valid),
        .z_ready  (z_ready),
        .busy     (busy)
    );

    // Stand-in for the external rotate-left unit.
    assign rot_a = (rot_b << rot_c) | (rot_b >> (32 - int'(rot_c)));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic s, input logic r, input logic v, input logic [31:0] d, input logic zr);
        start    = s;
        op_ror   = r;
        in_valid = v;
        in_data  = d;
        z_ready  = zr;
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input string tag, input logic r, input logic [31:0] b, input logic [31:0] cw,
                         input logic [31:0] exp_c, input logic [31:0] exp_z);
        applyStimulus(1'b1, r, 1'b0, 32'h0, 1'b0);
        checkOutput({tag, "_in_ready_b"}, 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, b, 1'b0);
        checkOutput({tag, "_rot_b"}, rot_b, b);
        applyStimulus(1'b0, 1'b0, 1'b1, cw, 1'b0);
        checkOutput({tag, "_rot_c"}, 32'(rot_c), exp_c);
        checkOutput({tag, "_zv_exec"}, 32'(z_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput({tag, "_zv_hold"}, 32'(z_valid), 32'd1);
        checkOutput({tag, "_z_data"}, z_data, exp_z);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
        checkOutput({tag, "_z_held"}, z_data, exp_z);
    endtask

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        op_ror   = 1'b0;
        in_data  = 32'h0;
        in_valid = 1'b0;
        z_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_z_valid", 32'(z_valid), 32'd0);
        checkOutput("rst_z_data", z_data, 32'h0);
        checkOutput("rst_rot_b", rot_b, 32'h0);
        clr = 1'b0;

        // Bus words presented while idle must not load anything.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hAAAA5555, 1'b0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_rot_b", rot_b, 32'h0);

        runOp("rol1", 1'b0, 32'h80000001, 32'h00000001, 32'd1, 32'h00000003);
        runOp("cnt25", 1'b0, 32'h00000001, 32'h00000025, 32'd5, 32'h00000020);
`ifdef ROT_OPERAND_SEQ_ROR_EN
        runOp("ror4", 1'b1, 32'h0000000F, 32'h00000004, 32'd28, 32'hF0000000);
`else
        runOp("ror4", 1'b1, 32'h0000000F, 32'h00000004, 32'd4, 32'h000000F0);
`endif
        runOp("cnt0", 1'b0, 32'hDEADBEEF, 32'h00000020, 32'd0, 32'hDEADBEEF);
        runOp("ror0", 1'b1, 32'hCAFEF00D, 32'hFFFFFFE0, 32'd0, 32'hCAFEF00D);

        // Stall in HOLD for three cycles, then accept with a back-to-back start.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000101, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000008, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_zv", 32'(z_valid), 32'd1);
            checkOutput("stall_z", z_data, 32'h00010100);
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h0BADBAD0, 1'b0);
        end
        checkOutput("stall_end_z", z_data, 32'h00010100);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
        checkOutput("b2b_zv", 32'(z_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h12340000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000010, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("b2b_z", z_data, 32'h00001234);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("b2b_idle", 32'(busy), 32'd0);

        // Asynchronous clear while waiting for the count word.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0);
        checkOutput("clr_pre_rot_b", rot_b, 32'h12345678);
        in_valid = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkOutput("clr_rot_b", rot_b, 32'h0);
        checkOutput("clr_zv", 32'(z_valid), 32'd0);
        checkOutput("clr_in_ready", 32'(in_ready), 32'd0);
        checkOutput("clr_z_data", z_data, 32'h0);
        #1;
        clr = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000003, 1'b0);
        checkOutput("clr_stays_idle", 32'(busy), 32'd0);
        runOp("post_clr", 1'b0, 32'h00000005, 32'h00000002, 32'd2, 32'h00000014);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rot_operand_seq.md
ROT_OPERAND_SEQ -- requirements
Module: rot_operand_seq

Interface
REQ-001 SHALL have parameter CLR_ON_ACCEPT, default 0: when 1, z_data returns to 0 on the cycle after result acceptance.
REQ-002 SHALL have port clk  in  1  single rising-edge clock for all state.
REQ-003 SHALL have port clr  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  in  1  request a new rotate; sampled only in IDLE, or in HOLD on the acceptance cycle.
REQ-005 SHALL have port op_ror  in  1  direction, 1 = rotate right; latched with start.
REQ-006 SHALL have port in_data  in  32  bus word: operand B first, then count word.
REQ-007 SHALL have ports in_valid  in  1 and in_ready  out  1, forming the bus-word handshake.
REQ-008 SHALL have ports rot_b  out  32 and rot_c  out  5, driving the rotate-left unit's Rb and Rc.
REQ-009 SHALL have port rot_a  in  32  rotate-left unit result (combinational from rot_b/rot_c).
REQ-010 SHALL have ports z_data  out  32, z_valid  out  1, z_ready  in  1, forming the result (Z register) handshake.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, GET_B, GET_C, EXEC, HOLD.
REQ-013 IDLE: in_ready=0, z_valid=0; start=1 -> GET_B and latch op_ror.
REQ-014 GET_B: in_ready=1; in_valid&in_ready -> latch in_data into B register, go to GET_C; otherwise stay.
REQ-015 GET_C: in_ready=1; on handshake, latch in_data[4:0] as count, ignore in_data[31:5], go to EXEC.
REQ-016 rot_b SHALL always equal the B register; rot_c SHALL always equal the effective count (REQ-025/026), both registered, never from in_data directly.
REQ-017 EXEC: one cycle; capture rot_a into the Z register at the clock edge ending EXEC, go to HOLD.
REQ-018 HOLD: z_valid=1; z_data stable until z_valid&z_ready.
REQ-019 On acceptance in HOLD: start=1 -> GET_B (new op_ror latched); otherwise -> IDLE.
REQ-020 Minimum latency: start at cycle 0, B at cycle 1, count at cycle 2, EXEC at cycle 3, z_valid high from cycle 4.
REQ-021 start outside IDLE and outside the HOLD acceptance cycle SHALL be ignored; in_valid outside GET_B/GET_C SHALL be ignored.
REQ-022 Count 0 SHALL pass B unchanged through the full sequence; there is no bypass of EXEC.
REQ-023 z_data SHALL hold its last value after acceptance when CLR_ON_ACCEPT=0.

Reset
REQ-024 clr SHALL force IDLE immediately, at any state including mid-handshake, and zero B, the count, op latch, Z register, z_valid and in_ready; busy=0. A partially loaded operation is discarded, not resumed.

Configuration
REQ-025 With ROT_OPERAND_SEQ_ROR_EN defined: if latched op_ror=1, effective count = (32 - count) mod 32, so count 0 stays 0.
REQ-026 Without ROT_OPERAND_SEQ_ROR_EN: op_ror is accepted but ignored; effective count = count (left rotate only).

Structure
REQ-027 Package rot_pkg SHALL hold DATA_W=32, CNT_W=5 and the state enumeration type.
REQ-028 No internal sub-module; the rotate-left unit SHALL be a sibling at datapath level, connected via rot_b/rot_c/rot_a.

Verification
REQ-029 Start, B=0x80000001, count=1, z_ready=1 -> z_data=0x00000003, z_valid first high at cycle 4.
REQ-030 Count word 0x00000025 with B=0x00000001 -> rot_c=5, z_data=0x00000020.
REQ-031 ROR_EN defined, op_ror=1, B=0x0000000F, count=4 -> rot_c=28, z_data=0xF0000000; undefined -> z_data=0x000000F0.
REQ-032 z_ready held low 3 cycles in HOLD -> z_valid=1 and z_data constant throughout; start with acceptance -> GET_B next cycle, busy stays 1.
REQ-033 clr pulsed in GET_C after B=0x12345678 is loaded -> next state IDLE, rot_b=0, z_valid=0, busy=0; a fresh full sequence then completes correctly.
